// File: rtl/laser_timer.sv
// Single-button laser pulse timer: a sampled high on B in OFF yields a pulse on X
// exactly ON_CYCLES clocks long, delayed one clock behind the FSM state.
module laser_timer #(
    parameter int unsigned ON_CYCLES = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic B,
    output logic X,
    input  logic Clk,
    input  logic Rst
);

    typedef enum logic {
        S_OFF = 1'b0,
        S_ON  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ON_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (B) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                // B is deliberately ignored here so a pulse can never be stretched.
                if (cnt_q == LAST) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= (state_q == S_ON);
        end
    end

    assign X = x_q;

endmodule

// File: tb/tb_laser_timer.sv
// Randomized bench for laser_timer at ON_CYCLES = 3, 1 and 7, checked against a
// model that tracks only the edge index at which each pulse was triggered.
module tb_laser_timer;

    localparam int NDUT = 3;
    localparam int NC [NDUT] = '{3, 1, 7};

    logic Clk;
    logic Rst;
    logic B;
    logic X3, X1, X7;

    int checks = 0;
    int errors = 0;

    int  edge_k;
    int  t0    [NDUT];
    bit  armed [NDUT];
    bit  exp_x [NDUT];

    laser_timer #(.ON_CYCLES(3), .CNT_W(8)) u_dut3 (.B(B), .X(X3), .Clk(Clk), .Rst(Rst));
    laser_timer #(.ON_CYCLES(1), .CNT_W(8)) u_dut1 (.B(B), .X(X1), .Clk(Clk), .Rst(Rst));
    laser_timer #(.ON_CYCLES(7), .CNT_W(8)) u_dut7 (.B(B), .X(X7), .Clk(Clk), .Rst(Rst));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    function automatic logic dut_x(input int i);
        case (i)
            0:       return X3;
            1:       return X1;
            default: return X7;
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_N%0d", tag, NC[i]), dut_x(i), exp_x[i]);
        end
    endtask

    // Pulse triggered at edge t0 keeps the FSM on for edges t0+1..t0+N; X shows that after each edge.
    task automatic model_edge(input logic b);
        bit on_before;
        edge_k++;
        for (int i = 0; i < NDUT; i++) begin
            on_before = armed[i] && (edge_k > t0[i]) && (edge_k <= t0[i] + NC[i]);
            exp_x[i]  = on_before;
            if (b && !on_before) begin
                t0[i]    = edge_k;
                armed[i] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            armed[i] = 1'b0;
            exp_x[i] = 1'b0;
            t0[i]    = 0;
        end
    endtask

    // Drive B at the falling edge, step the model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic b, input string tag);
        B = b;
        @(posedge Clk);
        model_edge(b);
        @(negedge Clk);
        check_all(tag);
    endtask

    // Rst raised between edges; X must drop before the next rising edge.
    task automatic async_reset(input logic b_at_release, input string tag);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check_all({tag, "_async"});
        @(negedge Clk);
        @(negedge Clk);
        check_all({tag, "_held"});
        B   = b_at_release;
        Rst = 1'b0;
    endtask

    initial begin
        edge_k = 0;
        model_reset();
        B   = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check_all("reset");
        Rst = 1'b0;

        // single trigger, then idle
        cycle(1'b1, "single");
        for (int j = 0; j < 9; j++) cycle(1'b0, "single");

        // retrigger two edges into the pulse must not extend it
        cycle(1'b1, "retrig");
        cycle(1'b0, "retrig");
        cycle(1'b1, "retrig");
        for (int j = 0; j < 8; j++) cycle(1'b0, "retrig");

        // held B: repeated pulses separated by one low cycle
        for (int j = 0; j < 16; j++) cycle(1'b1, "held");
        for (int j = 0; j < 8; j++) cycle(1'b0, "held");

        // reset mid-pulse after edge N+2, released with B low
        cycle(1'b1, "midrst");
        cycle(1'b0, "midrst");
        cycle(1'b0, "midrst");
        async_reset(1'b0, "midrst");
        for (int j = 0; j < 5; j++) cycle(1'b0, "post_rst");

        // B held through reset release starts a pulse on the first edge
        cycle(1'b1, "pre_hold");
        async_reset(1'b1, "hold_rel");
        for (int j = 0; j < 10; j++) cycle(1'b1, "hold_rel");
        for (int j = 0; j < 8; j++) cycle(1'b0, "hold_rel");

        // randomized traffic with occasional asynchronous resets
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset(1'($urandom_range(0, 1)), "rnd");
            end else if ($urandom_range(0, 3) == 0) begin
                for (int h = 0; h < int'($urandom_range(2, 10)); h++) cycle(1'b1, "rnd_hold");
            end else begin
                cycle(1'($urandom_range(0, 2) == 0), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
